// File: rtl/address_unit.sv
// Address-generation and program-counter stage: fetches the reset vector after reset,
// then holds PC, direct/indirect address registers and the opcode, and drives the address bus.
module address_unit #(
  parameter logic [15:0] RESET_VECTOR_LO = 16'hFFFC,
  parameter logic [7:0]  OPCODE_RESET    = 8'hEA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic [7:0]  alu_result,
  input  logic        instruction_load,
  input  logic        increment_pc,
  input  logic        dirl_load,
  input  logic        dirh_load,
  input  logic        indirl_load,
  input  logic        indirh_load,
  input  logic [1:0]  address_select,
  output logic [15:0] address,
  output logic [15:0] pc,
  output logic [7:0]  opcode_reg,
  output logic        ready
);

  typedef enum logic [1:0] {StRstLo, StRstHi, StRun} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  dirl_q, dirl_d;
  logic [7:0]  dirh_q, dirh_d;
  logic [7:0]  indirl_q, indirl_d;
  logic [7:0]  indirh_q, indirh_d;
  logic [7:0]  opcode_q, opcode_d;
  logic        ready_q, ready_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    dirl_d   = dirl_q;
    dirh_d   = dirh_q;
    indirl_d = indirl_q;
    indirh_d = indirh_q;
    opcode_d = opcode_q;
    unique case (state_q)
      StRstLo: begin
        pc_d[7:0] = data_in;
        state_d   = StRstHi;
      end
      StRstHi: begin
        pc_d[15:8] = data_in;
        state_d    = StRun;
      end
      StRun: begin
        // Strobes are independent; any combination lands on the same edge.
        if (increment_pc)     pc_d     = pc_q + 16'd1;
        if (instruction_load) opcode_d = data_in;
        if (dirl_load)        dirl_d   = alu_result;
        if (dirh_load)        dirh_d   = alu_result;
        if (indirl_load)      indirl_d = data_in;
        if (indirh_load)      indirh_d = data_in;
      end
      default: state_d = StRstLo;
    endcase
    ready_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StRstLo;
      pc_q     <= 16'h0000;
      dirl_q   <= 8'h00;
      dirh_q   <= 8'h00;
      indirl_q <= 8'h00;
      indirh_q <= 8'h00;
      opcode_q <= OPCODE_RESET;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      dirl_q   <= dirl_d;
      dirh_q   <= dirh_d;
      indirl_q <= indirl_d;
      indirh_q <= indirh_d;
      opcode_q <= opcode_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    address = pc_q;
    unique case (state_q)
      StRstLo: address = RESET_VECTOR_LO;
      StRstHi: address = RESET_VECTOR_LO + 16'd1;
      StRun: begin
        unique case (address_select)
          2'b00: address = pc_q;
          2'b01: address = {8'h00, dirl_q};
          2'b10: address = {dirh_q, dirl_q};
          2'b11: address = {indirh_q, indirl_q};
          default: address = pc_q;
        endcase
      end
      default: address = RESET_VECTOR_LO;
    endcase
  end

  assign pc         = pc_q;
  assign opcode_reg = opcode_q;
  assign ready      = ready_q;

endmodule
